sevga_vram_arbiter: RTL and testbench
=====================================

SEVGA_VRAM_ARBITER -- requirements
Module: sevga_vram_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning CPU write FIFO entries; the value SHALL be a power of two, minimum 2.
REQ-002 The block SHALL have port pixClk  input  1  pixel clock; all logic on rising edge.
REQ-003 The block SHALL have port nReset  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have port fetchReq  input  1  video fetch request; held high until fetchAck.
REQ-005 The block SHALL have port fetchAddr  input  15  video fetch VRAM address.
REQ-006 The block SHALL have port fetchBuf  input  1  fetch chip select: 0 = CE0, 1 = CE1.
REQ-007 The block SHALL have port fetchAck  output  1  one-clock pulse; fetchData valid.
REQ-008 The block SHALL have port fetchData  output  8  last fetched byte; holds until the next read completes.
REQ-009 The block SHALL have port wrPush  input  1  enqueue a CPU write, one per clock.
REQ-010 The block SHALL have port wrAddr  input  16  [15] chip select (0 = CE0), [14:0] VRAM address.
REQ-011 The block SHALL have port wrData  input  8  write byte.
REQ-012 The block SHALL have port wrFull  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 The block SHALL have port wrCount  output  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 The block SHALL have port wrOverflow  output  1  sticky: a push was dropped.
REQ-015 The block SHALL have port vramAddr  output  15  VRAM address.
REQ-016 The block SHALL have ports vramDataOut  output  8  and  vramDataOE  output  1  write data and its bus-drive enable.
REQ-017 The block SHALL have port vramDataIn  input  8  VRAM read data.
REQ-018 The block SHALL have ports nvramOE, nvramWE, nvramCE0, nvramCE1  output  1 each  active-low VRAM strobes.

Function
REQ-019 All outputs SHALL be registered; the state machine SHALL have states IDLE, RD_SETUP, RD_STROBE, RD_LATCH, RD_ACK, WR_SETUP, WR_STROBE1, WR_STROBE2, WR_HOLD.
REQ-020 In IDLE, the block SHALL select RD_SETUP when fetchReq=1; else WR_SETUP when wrCount>0; else it SHALL stay in IDLE; fetch SHALL have strict priority.
REQ-021 The read sequence SHALL be: RD_SETUP drives vramAddr=fetchAddr and the selected CE low, with nvramOE=1; RD_STROBE and RD_LATCH assert nvramOE=0; fetchData SHALL capture vramDataIn at the end of RD_LATCH.
REQ-022 In RD_ACK, fetchAck=1 and all strobes SHALL be high; the next state SHALL be IDLE.
REQ-023 fetchReq sampled in IDLE at cycle t SHALL yield fetchAck at cycle t+4.
REQ-024 In the IDLE cycle directly after RD_ACK, fetchReq SHALL be ignored, so one request produces exactly one access.
REQ-025 In WR_SETUP, the block SHALL pop the FIFO head and drive vramAddr, vramDataOut and vramDataOE=1, with CE selected by addr[15] and nvramWE=1.
REQ-026 WR_STROBE1 and WR_STROBE2 SHALL assert nvramWE=0.
REQ-027 In WR_HOLD, nvramWE=1, with CE low and data still driven; the next state SHALL be IDLE.
REQ-028 A write sequence SHALL take 4 clocks, so a fetchReq waits at most 4 clocks before RD_SETUP.
REQ-029 In IDLE and RD_*, vramDataOE SHALL be 0, and nvramOE and nvramWE SHALL never be low in the same cycle.
REQ-030 CE0 and CE1 SHALL never be low simultaneously, and SHALL both be high in IDLE and RD_ACK.
REQ-031 The FIFO SHALL be first-in first-out.
REQ-032 A push when wrFull=1 and no pop occurs that cycle SHALL be dropped and SHALL set wrOverflow.
REQ-033 A push and pop in the same cycle SHALL be accepted even when full, with count unchanged.
REQ-034 A push into an empty FIFO SHALL be eligible for grant no earlier than the following IDLE cycle.
REQ-035 FIFO pointers SHALL wrap modulo FIFO_DEPTH; wrCount SHALL never exceed FIFO_DEPTH nor underflow.
REQ-036 A fetchReq arriving mid-write SHALL not abort the write.

Reset
REQ-037 While nReset=0, the block SHALL force state=IDLE, FIFO empty (wrCount=0), wrFull=0 and wrOverflow=0.
REQ-038 While nReset=0, the block SHALL force fetchAck=0, fetchData=0, vramAddr=0, vramDataOut=0 and vramDataOE=0.
REQ-039 While nReset=0, nvramOE, nvramWE, nvramCE0 and nvramCE1 SHALL all be 1.
REQ-040 Reset asserted mid-access SHALL abandon the access immediately; queued writes SHALL be lost.
REQ-041 The first clock after deassertion SHALL be IDLE.

Verification
REQ-042 Read: fetchReq=1, fetchAddr=15'h1234, fetchBuf=1, vramDataIn=8'hA5 -> nvramCE1=0 for 3 clocks, OE low for 2, fetchAck at t+4 with fetchData=8'hA5, CE0 high throughout.
REQ-043 Write: push wrAddr=16'h8010, wrData=8'h3C -> vramAddr=15'h0010, CE1 low for 4 clocks, WE low for 2, vramDataOut=8'h3C, wrCount returns to 0.
REQ-044 Priority: FIFO holds 2 entries and fetchReq rises during WR_STROBE1 -> the write completes, the read follows, then the second write.
REQ-045 Overflow: 5 pushes in consecutive clocks with fetchReq held high -> wrFull=1 after the 4th, wrOverflow=1, and the 5th entry is never written.
REQ-046 Simultaneous events: push while full in a WR_SETUP cycle -> accepted, wrOverflow=0, wrCount stays 4.
REQ-047 Reset mid-write: nReset=0 in WR_STROBE1 -> all strobes high asynchronously, wrCount=0, and the block is in IDLE after release.

Source files
------------

// File: rtl/sevga_vram_arbiter.sv
// SEVGA VRAM arbiter: shares one asynchronous VRAM port between the video
// fetch engine (strict priority) and a small CPU write FIFO. Every output,
// including the active-low VRAM strobes, comes straight from a flop.

module sevga_vram_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          pixClk,
  input  logic                          nReset,
  input  logic                          fetchReq,
  input  logic [14:0]                   fetchAddr,
  input  logic                          fetchBuf,
  output logic                          fetchAck,
  output logic [7:0]                    fetchData,
  input  logic                          wrPush,
  input  logic [15:0]                   wrAddr,
  input  logic [7:0]                    wrData,
  output logic                          wrFull,
  output logic [$clog2(FIFO_DEPTH):0]   wrCount,
  output logic                          wrOverflow,
  output logic [14:0]                   vramAddr,
  output logic [7:0]                    vramDataOut,
  output logic                          vramDataOE,
  input  logic [7:0]                    vramDataIn,
  output logic                          nvramOE,
  output logic                          nvramWE,
  output logic                          nvramCE0,
  output logic                          nvramCE1
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    RD_SETUP,
    RD_STROBE,
    RD_LATCH,
    RD_ACK,
    WR_SETUP,
    WR_STROBE1,
    WR_STROBE2,
    WR_HOLD
  } arbStateT;

  arbStateT state;
  arbStateT nextState;

  // Write FIFO storage: each entry is {chip select, address, data}.
  logic [23:0]      fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] countNext;
  logic [23:0]      fifoHead;
  logic             pop;
  logic             pushOk;

  // Access bookkeeping: latched chip select and the one-cycle fetch lockout.
  logic ceSel;
  logic skipFetch;

  // Next-cycle values for the registered outputs.
  logic loadRead;
  logic loadWrite;
  logic nextSel;
  logic ceActive;
  logic oeActive;
  logic weActive;
  logic dataDrive;
  logic ackNext;

  assign fifoHead = fifoMem[rdPtr];

  // The head leaves the FIFO during WR_SETUP; a push is taken if there is room
  // now or a slot is being freed by that same pop.
  assign pop    = (state == WR_SETUP) && (wrCount != '0);
  assign pushOk = wrPush && ((wrCount != DEPTH_CNT) || pop);

  // Occupancy after this clock, covering push-only, pop-only and push+pop.
  always_comb begin
    countNext = wrCount;
    if (pushOk && !pop) begin
      countNext = wrCount + CNT_W'(1);
    end else if (!pushOk && pop) begin
      countNext = wrCount - CNT_W'(1);
    end
  end

  // FIFO payload storage; contents need no reset because the pointers define validity.
  always_ff @(posedge pixClk) begin
    if (pushOk) begin
      fifoMem[wrPtr] <= {wrAddr, wrData};
    end
  end

  // FIFO pointers, occupancy, full flag and sticky overflow flag.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      wrCount    <= '0;
      wrFull     <= 1'b0;
      wrOverflow <= 1'b0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      wrCount <= countNext;
      wrFull  <= (countNext == DEPTH_CNT);
      if (wrPush && !pushOk) begin
        wrOverflow <= 1'b1;
      end
    end
  end

  // Next-state choice plus decode of the strobe pattern for the state being entered.
  always_comb begin
    nextState = state;
    ceActive  = 1'b0;
    oeActive  = 1'b0;
    weActive  = 1'b0;
    dataDrive = 1'b0;
    ackNext   = 1'b0;
    loadRead  = 1'b0;
    loadWrite = 1'b0;
    nextSel   = ceSel;

    unique case (state)
      IDLE: begin
        if (fetchReq && !skipFetch) begin
          nextState = RD_SETUP;
        end else if (wrCount != '0) begin
          nextState = WR_SETUP;
        end
      end
      RD_SETUP:   nextState = RD_STROBE;
      RD_STROBE:  nextState = RD_LATCH;
      RD_LATCH:   nextState = RD_ACK;
      RD_ACK:     nextState = IDLE;
      WR_SETUP:   nextState = WR_STROBE1;
      WR_STROBE1: nextState = WR_STROBE2;
      WR_STROBE2: nextState = WR_HOLD;
      WR_HOLD:    nextState = IDLE;
      default:    nextState = IDLE;
    endcase

    loadRead  = (state == IDLE) && (nextState == RD_SETUP);
    loadWrite = (state == IDLE) && (nextState == WR_SETUP);
    if (loadRead) begin
      nextSel = fetchBuf;
    end else if (loadWrite) begin
      nextSel = fifoHead[23];
    end

    unique case (nextState)
      RD_SETUP: begin
        ceActive = 1'b1;
      end
      RD_STROBE, RD_LATCH: begin
        ceActive = 1'b1;
        oeActive = 1'b1;
      end
      RD_ACK: begin
        ackNext = 1'b1;
      end
      WR_SETUP, WR_HOLD: begin
        ceActive  = 1'b1;
        dataDrive = 1'b1;
      end
      WR_STROBE1, WR_STROBE2: begin
        ceActive  = 1'b1;
        dataDrive = 1'b1;
        weActive  = 1'b1;
      end
      default: begin
        ceActive = 1'b0;
      end
    endcase
  end

  // State register and all registered bus outputs; reset drops any access at once.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      ceSel       <= 1'b0;
      skipFetch   <= 1'b0;
      fetchAck    <= 1'b0;
      fetchData   <= '0;
      vramAddr    <= '0;
      vramDataOut <= '0;
      vramDataOE  <= 1'b0;
      nvramOE     <= 1'b1;
      nvramWE     <= 1'b1;
      nvramCE0    <= 1'b1;
      nvramCE1    <= 1'b1;
    end else begin
      state      <= nextState;
      ceSel      <= nextSel;
      skipFetch  <= (state == RD_ACK);
      fetchAck   <= ackNext;
      vramDataOE <= dataDrive;
      nvramOE    <= !oeActive;
      nvramWE    <= !weActive;
      nvramCE0   <= !(ceActive && !nextSel);
      nvramCE1   <= !(ceActive && nextSel);
      if (loadRead) begin
        vramAddr <= fetchAddr;
      end else if (loadWrite) begin
        vramAddr    <= fifoHead[22:8];
        vramDataOut <= fifoHead[7:0];
      end
      if (state == RD_LATCH) begin
        fetchData <= vramDataIn;
      end
    end
  end

endmodule

// File: tb/tb_sevga_vram_arbiter.sv
// Directed bench for sevga_vram_arbiter: a cycle table for a plain read and
// write, then hand-written sequences for priority, overflow, push-while-full
// and reset in the middle of a write.

module tb_sevga_vram_arbiter;

  localparam int FIFO_DEPTH = 4;

  logic        pixClk = 1'b0;
  logic        nReset;
  logic        fetchReq;
  logic [14:0] fetchAddr;
  logic        fetchBuf;
  logic        fetchAck;
  logic [7:0]  fetchData;
  logic        wrPush;
  logic [15:0] wrAddr;
  logic [7:0]  wrData;
  logic        wrFull;
  logic [2:0]  wrCount;
  logic        wrOverflow;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataOut;
  logic        vramDataOE;
  logic [7:0]  vramDataIn;
  logic        nvramOE;
  logic        nvramWE;
  logic        nvramCE0;
  logic        nvramCE1;

  sevga_vram_arbiter #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .pixClk      (pixClk),
    .nReset      (nReset),
    .fetchReq    (fetchReq),
    .fetchAddr   (fetchAddr),
    .fetchBuf    (fetchBuf),
    .fetchAck    (fetchAck),
    .fetchData   (fetchData),
    .wrPush      (wrPush),
    .wrAddr      (wrAddr),
    .wrData      (wrData),
    .wrFull      (wrFull),
    .wrCount     (wrCount),
    .wrOverflow  (wrOverflow),
    .vramAddr    (vramAddr),
    .vramDataOut (vramDataOut),
    .vramDataOE  (vramDataOE),
    .vramDataIn  (vramDataIn),
    .nvramOE     (nvramOE),
    .nvramWE     (nvramWE),
    .nvramCE0    (nvramCE0),
    .nvramCE1    (nvramCE1)
  );

  always #5 pixClk = ~pixClk;

  typedef struct {
    logic        fetchReq;
    logic [14:0] fetchAddr;
    logic        fetchBuf;
    logic [7:0]  vramDataIn;
    logic        wrPush;
    logic [15:0] wrAddr;
    logic [7:0]  wrData;
    logic [3:0]  expStrobes;
    logic        expAck;
    logic [7:0]  expFetchData;
    logic [14:0] expAddr;
    logic        expDataOE;
    logic [7:0]  expDataOut;
    logic [2:0]  expCount;
  } vecT;

  localparam int NVEC = 11;
  vecT vecs [NVEC];

  int total = 0;
  int bad = 0;
  int protoErr = 0;
  logic [23:0] writeLog [$];
  logic prevWe = 1'b1;
  logic [23:0] simVals [5];
  logic [23:0] ovfVals [5];

  // Watches the bus each cycle: illegal strobe combinations and the start of every write.
  always @(negedge pixClk) begin
    if (nReset) begin
      if ((!nvramOE && !nvramWE) || (!nvramCE0 && !nvramCE1) || (vramDataOE && !nvramOE)) begin
        protoErr++;
      end
      if (!nvramWE && prevWe) begin
        writeLog.push_back({!nvramCE1, vramAddr, vramDataOut});
      end
    end
    prevWe = nvramWE;
  end

  function automatic logic [3:0] strobes();
    return {nvramOE, nvramWE, nvramCE0, nvramCE1};
  endfunction

  task automatic tick();
    @(posedge pixClk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkStrobes(input string name, input logic [3:0] exp);
    checkOutput(name, 32'(strobes()), 32'(exp));
  endtask

  task automatic applyStimulus(input vecT v);
    fetchReq   = v.fetchReq;
    fetchAddr  = v.fetchAddr;
    fetchBuf   = v.fetchBuf;
    vramDataIn = v.vramDataIn;
    wrPush     = v.wrPush;
    wrAddr     = v.wrAddr;
    wrData     = v.wrData;
    tick();
  endtask

  task automatic checkVector(input int i, input vecT v);
    checkStrobes($sformatf("vec%0d strobes", i), v.expStrobes);
    checkOutput($sformatf("vec%0d fetchAck", i), 32'(fetchAck), 32'(v.expAck));
    checkOutput($sformatf("vec%0d fetchData", i), 32'(fetchData), 32'(v.expFetchData));
    checkOutput($sformatf("vec%0d vramAddr", i), 32'(vramAddr), 32'(v.expAddr));
    checkOutput($sformatf("vec%0d vramDataOE", i), 32'(vramDataOE), 32'(v.expDataOE));
    checkOutput($sformatf("vec%0d vramDataOut", i), 32'(vramDataOut), 32'(v.expDataOut));
    checkOutput($sformatf("vec%0d wrCount", i), 32'(wrCount), 32'(v.expCount));
  endtask

  task automatic clearInputs();
    fetchReq   = 1'b0;
    fetchAddr  = '0;
    fetchBuf   = 1'b0;
    vramDataIn = '0;
    wrPush     = 1'b0;
    wrAddr     = '0;
    wrData     = '0;
  endtask

  task automatic resetDut();
    clearInputs();
    nReset = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
    tick();
  endtask

  initial begin
    // Strobes are {nOE, nWE, nCE0, nCE1}.
    vecs[0]  = '{1'b1, 15'h1234, 1'b1, 8'hA5, 1'b0, 16'h0000, 8'h00, 4'b1110, 1'b0, 8'h00, 15'h1234, 1'b0, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 15'h1234, 1'b1, 8'hA5, 1'b0, 16'h0000, 8'h00, 4'b0110, 1'b0, 8'h00, 15'h1234, 1'b0, 8'h00, 3'd0};
    vecs[2]  = '{1'b1, 15'h1234, 1'b1, 8'hA5, 1'b0, 16'h0000, 8'h00, 4'b0110, 1'b0, 8'h00, 15'h1234, 1'b0, 8'h00, 3'd0};
    vecs[3]  = '{1'b1, 15'h1234, 1'b1, 8'hA5, 1'b0, 16'h0000, 8'h00, 4'b1111, 1'b1, 8'hA5, 15'h1234, 1'b0, 8'h00, 3'd0};
    vecs[4]  = '{1'b0, 15'h1234, 1'b1, 8'hA5, 1'b0, 16'h0000, 8'h00, 4'b1111, 1'b0, 8'hA5, 15'h1234, 1'b0, 8'h00, 3'd0};
    vecs[5]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 16'h8010, 8'h3C, 4'b1111, 1'b0, 8'hA5, 15'h1234, 1'b0, 8'h00, 3'd1};
    vecs[6]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 16'h8010, 8'h3C, 4'b1110, 1'b0, 8'hA5, 15'h0010, 1'b1, 8'h3C, 3'd1};
    vecs[7]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 4'b1010, 1'b0, 8'hA5, 15'h0010, 1'b1, 8'h3C, 3'd0};
    vecs[8]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 4'b1010, 1'b0, 8'hA5, 15'h0010, 1'b1, 8'h3C, 3'd0};
    vecs[9]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 4'b1110, 1'b0, 8'hA5, 15'h0010, 1'b1, 8'h3C, 3'd0};
    vecs[10] = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 4'b1111, 1'b0, 8'hA5, 15'h0010, 1'b0, 8'h3C, 3'd0};

    simVals[0] = 24'h0011A1;
    simVals[1] = 24'h8022B2;
    simVals[2] = 24'h0033C3;
    simVals[3] = 24'h8044D4;
    simVals[4] = 24'h006666;
    ovfVals[0] = 24'h000101;
    ovfVals[1] = 24'h800202;
    ovfVals[2] = 24'h000303;
    ovfVals[3] = 24'h800404;
    ovfVals[4] = 24'h0055EE;

    clearInputs();
    nReset = 1'b0;
    tick();
    tick();
    checkStrobes("reset strobes", 4'b1111);
    checkOutput("reset fetchAck", 32'(fetchAck), 32'(1'b0));
    checkOutput("reset fetchData", 32'(fetchData), 32'(8'h00));
    checkOutput("reset vramAddr", 32'(vramAddr), 32'(15'h0000));
    checkOutput("reset vramDataOut", 32'(vramDataOut), 32'(8'h00));
    checkOutput("reset vramDataOE", 32'(vramDataOE), 32'(1'b0));
    checkOutput("reset wrCount", 32'(wrCount), 32'(3'd0));
    checkOutput("reset wrFull", 32'(wrFull), 32'(1'b0));
    checkOutput("reset wrOverflow", 32'(wrOverflow), 32'(1'b0));
    nReset = 1'b1;
    tick();
    checkStrobes("post-reset idle", 4'b1111);

    // Basic read then basic write, cycle by cycle.
    writeLog.delete();
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end
    clearInputs();
    checkOutput("table write count", 32'(writeLog.size()), 32'd1);
    if (writeLog.size() > 0) begin
      checkOutput("table write entry", 32'(writeLog[0]), 32'(24'h80103C));
    end

    // Fetch raised during WR_STROBE1: write finishes, read next, then second write.
    wrPush = 1'b1; wrAddr = 16'h0005; wrData = 8'h11;
    tick();
    checkOutput("prio count after push1", 32'(wrCount), 32'd1);
    wrAddr = 16'h8006; wrData = 8'h22;
    tick();
    checkStrobes("prio w1 setup", 4'b1101);
    checkOutput("prio w1 addr", 32'(vramAddr), 32'(15'h0005));
    checkOutput("prio count after push2", 32'(wrCount), 32'd2);
    wrPush = 1'b0;
    tick();
    checkStrobes("prio w1 strobe1", 4'b1001);
    fetchReq = 1'b1; fetchAddr = 15'h0777; fetchBuf = 1'b0; vramDataIn = 8'h5A;
    tick();
    checkStrobes("prio w1 strobe2", 4'b1001);
    tick();
    checkStrobes("prio w1 hold", 4'b1101);
    checkOutput("prio w1 hold dataOE", 32'(vramDataOE), 32'(1'b1));
    tick();
    checkStrobes("prio idle", 4'b1111);
    tick();
    checkStrobes("prio rd setup", 4'b1101);
    checkOutput("prio rd addr", 32'(vramAddr), 32'(15'h0777));
    tick();
    tick();
    checkStrobes("prio rd latch", 4'b0101);
    tick();
    checkOutput("prio rd ack", 32'(fetchAck), 32'(1'b1));
    checkOutput("prio rd data", 32'(fetchData), 32'(8'h5A));
    checkStrobes("prio rd ack strobes", 4'b1111);
    fetchReq = 1'b0;
    tick();
    checkStrobes("prio post-ack idle", 4'b1111);
    tick();
    checkStrobes("prio w2 setup", 4'b1110);
    checkOutput("prio w2 addr", 32'(vramAddr), 32'(15'h0006));
    checkOutput("prio w2 data", 32'(vramDataOut), 32'(8'h22));
    repeat (4) tick();
    checkOutput("prio final count", 32'(wrCount), 32'd0);
    checkStrobes("prio final idle", 4'b1111);

    // Push while full in the WR_SETUP cycle is accepted.
    resetDut();
    writeLog.delete();
    fetchReq = 1'b1; fetchAddr = 15'h0100; fetchBuf = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      wrPush = 1'b1;
      {wrAddr, wrData} = simVals[i];
      tick();
    end
    checkOutput("sim full before setup", 32'(wrFull), 32'(1'b1));
    wrPush = 1'b0; fetchReq = 1'b0;
    tick();
    checkOutput("sim count in setup", 32'(wrCount), 32'd4);
    wrPush = 1'b1;
    {wrAddr, wrData} = simVals[4];
    tick();
    wrPush = 1'b0;
    checkOutput("sim count after push+pop", 32'(wrCount), 32'd4);
    checkOutput("sim overflow", 32'(wrOverflow), 32'(1'b0));
    checkOutput("sim full", 32'(wrFull), 32'(1'b1));
    repeat (30) tick();
    checkOutput("sim drained count", 32'(wrCount), 32'd0);
    checkOutput("sim write total", 32'(writeLog.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < writeLog.size()) begin
        checkOutput($sformatf("sim write %0d", i), 32'(writeLog[i]), 32'(simVals[i]));
      end
    end

    // Five back-to-back pushes with fetch held high: fifth is dropped.
    resetDut();
    writeLog.delete();
    fetchReq = 1'b1; fetchAddr = 15'h0200; fetchBuf = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      wrPush = 1'b1;
      {wrAddr, wrData} = ovfVals[i];
      tick();
      if (i == 3) begin
        checkOutput("ovf full after 4th", 32'(wrFull), 32'(1'b1));
        checkOutput("ovf no overflow after 4th", 32'(wrOverflow), 32'(1'b0));
      end
    end
    wrPush = 1'b0;
    checkOutput("ovf count after 5th", 32'(wrCount), 32'd4);
    checkOutput("ovf flag after 5th", 32'(wrOverflow), 32'(1'b1));
    repeat (60) tick();
    fetchReq = 1'b0;
    repeat (6) tick();
    checkOutput("ovf drained count", 32'(wrCount), 32'd0);
    checkOutput("ovf sticky", 32'(wrOverflow), 32'(1'b1));
    checkOutput("ovf write total", 32'(writeLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < writeLog.size()) begin
        checkOutput($sformatf("ovf write %0d", i), 32'(writeLog[i]), 32'(ovfVals[i]));
      end
    end

    // Reset asserted during WR_STROBE1 drops the access and the queue.
    resetDut();
    wrPush = 1'b1; wrAddr = 16'h8077; wrData = 8'h99;
    tick();
    wrAddr = 16'h0078; wrData = 8'h98;
    tick();
    wrPush = 1'b0;
    tick();
    checkStrobes("rst in strobe1", 4'b1010);
    #1 nReset = 1'b0;
    #1;
    checkStrobes("rst async strobes", 4'b1111);
    checkOutput("rst async count", 32'(wrCount), 32'd0);
    checkOutput("rst async dataOE", 32'(vramDataOE), 32'(1'b0));
    checkOutput("rst async addr", 32'(vramAddr), 32'(15'h0000));
    tick();
    tick();
    nReset = 1'b1;
    writeLog.delete();
    repeat (10) tick();
    checkOutput("rst queue lost", 32'(writeLog.size()), 32'd0);
    checkOutput("rst count after release", 32'(wrCount), 32'd0);
    checkStrobes("rst idle after release", 4'b1111);
    fetchReq = 1'b1; fetchAddr = 15'h4321; fetchBuf = 1'b1; vramDataIn = 8'h96;
    tick();
    checkStrobes("rst rd setup", 4'b1110);
    checkOutput("rst rd addr", 32'(vramAddr), 32'(15'h4321));
    repeat (3) tick();
    checkOutput("rst rd ack", 32'(fetchAck), 32'(1'b1));
    checkOutput("rst rd data", 32'(fetchData), 32'(8'h96));
    tick();
    tick();
    checkStrobes("held req ignored after ack", 4'b1111);
    checkOutput("held req no second ack", 32'(fetchAck), 32'(1'b0));
    fetchReq = 1'b0;
    tick();
    checkStrobes("idle after release of req", 4'b1111);

    checkOutput("bus protocol violations", 32'(protoErr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
